// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM for the multicycle RV32I core. Sequences
//               fetch, decode, execute, memory and writeback over a shared
//               datapath (one memory port, ALU, immediate extender and
//               register file), stalling on a single memory ready handshake.
//
// Ports       : clk        core clock, rising edge
//               rst_n      asynchronous active-low reset
//               op         instr[6:0] from the instruction register
//               zero       ALU zero flag
//               mem_ready  memory completes the current access this cycle
//               immsrc     extender format select (I=00 S=01 B=10 J=11)
//               pcwrite    PC register enable
//               adrsrc     memory address mux (0 PC, 1 result)
//               memwrite   memory write strobe
//               mem_req    memory access request
//               irwrite    instruction / OldPC register enable
//               resultsrc  result mux (00 ALUOut, 01 Data, 10 ALUResult)
//               alusrca    ALU A select (00 PC, 01 OldPC, 10 rd1)
//               alusrcb    ALU B select (00 rd2, 01 immext, 10 const 4)
//               aluop      ALU decoder op (00 add, 01 sub, 10 funct)
//               regwrite   register file write enable
//               illegal    one-cycle pulse on an unsupported opcode
//               state      current state code (debug)
//
// Revision    : 1.0 - initial release
// ============================================================================

module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] immsrc,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       mem_req,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // An out-of-range reset code would park the FSM in an unreachable
    // state for one cycle; fall back to FETCH so reset is always clean.
    localparam state_t c_reset_state = (RESET_STATE <= 4'd11) ?
                                       state_t'(RESET_STATE) : S_FETCH;

    // ------------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_op_lw   = 7'b0000011;
    localparam logic [6:0] c_op_sw   = 7'b0100011;
    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_ialu = 7'b0010011;
    localparam logic [6:0] c_op_beq  = 7'b1100011;
    localparam logic [6:0] c_op_jal  = 7'b1101111;

    // Mux encodings
    localparam logic [1:0] c_imm_i     = 2'b00;
    localparam logic [1:0] c_imm_s     = 2'b01;
    localparam logic [1:0] c_imm_b     = 2'b10;
    localparam logic [1:0] c_imm_j     = 2'b11;

    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_data   = 2'b01;
    localparam logic [1:0] c_res_alures = 2'b10;

    localparam logic [1:0] c_a_pc    = 2'b00;
    localparam logic [1:0] c_a_oldpc = 2'b01;
    localparam logic [1:0] c_a_rd1   = 2'b10;

    localparam logic [1:0] c_b_rd2   = 2'b00;
    localparam logic [1:0] c_b_imm   = 2'b01;
    localparam logic [1:0] c_b_four  = 2'b10;

    localparam logic [1:0] c_alu_add  = 2'b00;
    localparam logic [1:0] c_alu_sub  = 2'b01;
    localparam logic [1:0] c_alu_func = 2'b10;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t r_state;
    state_t w_next_state;

    logic w_is_lw;
    logic w_is_sw;
    logic w_is_r;
    logic w_is_ialu;
    logic w_is_beq;
    logic w_is_jal;

    logic w_pcwrite;
    logic w_memwrite;
    logic w_mem_req;
    logic w_irwrite;
    logic w_regwrite;
    logic w_illegal;

    // ------------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------------
    assign w_is_lw   = (op == c_op_lw);
    assign w_is_sw   = (op == c_op_sw);
    assign w_is_r    = (op == c_op_r);
    assign w_is_ialu = (op == c_op_ialu);
    assign w_is_beq  = (op == c_op_beq);
    assign w_is_jal  = (op == c_op_jal);

    // Immediate format follows the opcode in every state so the extender
    // output is already valid when DECODE computes the branch/jump target.
    always_comb begin
        immsrc = c_imm_i;
        if (w_is_sw) begin
            immsrc = c_imm_s;
        end else if (w_is_beq) begin
            immsrc = c_imm_b;
        end else if (w_is_jal) begin
            immsrc = c_imm_j;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_reset_state;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        w_pcwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_mem_req    = 1'b0;
        w_irwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_illegal    = 1'b0;
        adrsrc       = 1'b0;
        resultsrc    = c_res_aluout;
        alusrca      = c_a_pc;
        alusrcb      = c_b_rd2;
        aluop        = c_alu_add;

        case (r_state)
            S_FETCH: begin
                // PC+4 goes straight through ALUResult into the PC
                w_mem_req = 1'b1;
                alusrca   = c_a_pc;
                alusrcb   = c_b_four;
                resultsrc = c_res_alures;
                aluop     = c_alu_add;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next_state = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                // OldPC + imm lands in ALUOut for a later BEQ/JAL
                alusrca = c_a_oldpc;
                alusrcb = c_b_imm;
                aluop   = c_alu_add;
                if (w_is_lw || w_is_sw) begin
                    w_next_state = S_MEMADR;
                end else if (w_is_r) begin
                    w_next_state = S_EXECR;
                end else if (w_is_ialu) begin
                    w_next_state = S_EXECI;
                end else if (w_is_beq) begin
                    w_next_state = S_BEQ;
                end else if (w_is_jal) begin
                    w_next_state = S_JAL;
                end else begin
                    w_next_state = S_TRAP;
                end
            end

            S_MEMADR: begin
                alusrca = c_a_rd1;
                alusrcb = c_b_imm;
                aluop   = c_alu_add;
                // Only lw/sw reach here; anything else is treated as a load
                // path would be wrong, so route non-stores back via MEMREAD
                // only for lw and otherwise to MEMWRITE for sw.
                if (w_is_sw) begin
                    w_next_state = S_MEMWRITE;
                end else if (w_is_lw) begin
                    w_next_state = S_MEMREAD;
                end else begin
                    w_next_state = S_FETCH;
                end
            end

            S_MEMREAD: begin
                w_mem_req = 1'b1;
                adrsrc    = 1'b1;
                resultsrc = c_res_aluout;
                w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end

            S_MEMWB: begin
                resultsrc  = c_res_data;
                w_regwrite = 1'b1;
                w_next_state = S_FETCH;
            end

            S_MEMWRITE: begin
                w_mem_req  = 1'b1;
                w_memwrite = 1'b1;
                adrsrc     = 1'b1;
                resultsrc  = c_res_aluout;
                w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            end

            S_EXECR: begin
                alusrca = c_a_rd1;
                alusrcb = c_b_rd2;
                aluop   = c_alu_func;
                w_next_state = S_ALUWB;
            end

            S_EXECI: begin
                alusrca = c_a_rd1;
                alusrcb = c_b_imm;
                aluop   = c_alu_func;
                w_next_state = S_ALUWB;
            end

            S_ALUWB: begin
                resultsrc  = c_res_aluout;
                w_regwrite = 1'b1;
                w_next_state = S_FETCH;
            end

            S_BEQ: begin
                // Target already sits in ALUOut; the subtract only sets zero
                alusrca   = c_a_rd1;
                alusrcb   = c_b_rd2;
                aluop     = c_alu_sub;
                resultsrc = c_res_aluout;
                w_pcwrite = zero;
                w_next_state = S_FETCH;
            end

            S_JAL: begin
                // PC <- ALUOut (target), ALU meanwhile forms OldPC+4 for rd
                alusrca   = c_a_oldpc;
                alusrcb   = c_b_four;
                aluop     = c_alu_add;
                resultsrc = c_res_aluout;
                w_pcwrite = 1'b1;
                w_next_state = S_ALUWB;
            end

            S_TRAP: begin
                w_illegal = 1'b1;
                w_next_state = S_FETCH;
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Enables are forced low while reset is held: the state register already
    // sits at FETCH, whose decode would otherwise request memory.
    // ------------------------------------------------------------------------
    assign pcwrite  = w_pcwrite  & rst_n;
    assign memwrite = w_memwrite & rst_n;
    assign mem_req  = w_mem_req  & rst_n;
    assign irwrite  = w_irwrite  & rst_n;
    assign regwrite = w_regwrite & rst_n;
    assign illegal  = w_illegal  & rst_n;

    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each cycle the
//               expected output vector for the intended state is pushed to a
//               scoreboard queue when inputs are driven, and popped and
//               compared on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] immsrc;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       mem_req;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       illegal;
    logic [3:0] state;

    int total;
    int bad;
    int pc_cnt;
    int ir_cnt;
    int rw_cnt;
    int mw_cnt;
    int il_cnt;

    logic [20:0] exp_q[$];

    multicycle_ctrl #(
        .RESET_STATE(4'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .immsrc    (immsrc),
        .pcwrite   (pcwrite),
        .adrsrc    (adrsrc),
        .memwrite  (memwrite),
        .mem_req   (mem_req),
        .irwrite   (irwrite),
        .resultsrc (resultsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .regwrite  (regwrite),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: state, immsrc, pcwrite, adrsrc, memwrite, mem_req,
    // irwrite, resultsrc, alusrca, alusrcb, aluop, regwrite, illegal
    function automatic logic [20:0] actual_vec();
        return {state, immsrc, pcwrite, adrsrc, memwrite, mem_req, irwrite,
                resultsrc, alusrca, alusrcb, aluop, regwrite, illegal};
    endfunction

    // Output table taken from the per-state description of the controller
    function automatic logic [20:0] expect_vec(input logic [3:0] s,
                                               input logic [6:0] o,
                                               input logic z,
                                               input logic mr,
                                               input logic rn);
        logic [1:0] im;
        logic pw, ad, mw, mq, iw, rw, il;
        logic [1:0] rs, sa, sb, ao;
        im = 2'b00;
        if (o == 7'b0100011) im = 2'b01;
        if (o == 7'b1100011) im = 2'b10;
        if (o == 7'b1101111) im = 2'b11;
        pw = 0; ad = 0; mw = 0; mq = 0; iw = 0; rw = 0; il = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
        case (s)
            4'd0:  begin mq = 1; sb = 2'b10; rs = 2'b10; iw = mr; pw = mr; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  begin mq = 1; ad = 1; end
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin mq = 1; mw = 1; ad = 1; end
            4'd6:  begin sa = 2'b10; ao = 2'b10; end
            4'd7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            4'd8:  begin rw = 1; end
            4'd9:  begin sa = 2'b10; ao = 2'b01; pw = z; end
            4'd10: begin sa = 2'b01; sb = 2'b10; pw = 1; end
            4'd11: begin il = 1; end
            default: ;
        endcase
        if (!rn) begin
            pw = 0; mw = 0; mq = 0; iw = 0; rw = 0; il = 0;
        end
        return {s, im, pw, ad, mw, mq, iw, rs, sa, sb, ao, rw, il};
    endfunction

    task automatic clear_counts();
        pc_cnt = 0; ir_cnt = 0; rw_cnt = 0; mw_cnt = 0; il_cnt = 0;
    endtask

    // One clock cycle: drive inputs after the edge, push the expectation,
    // then pop and compare at the falling edge.
    task automatic cyc(input string name, input logic mr, input logic z,
                       input logic [3:0] exp_state);
        logic [20:0] e;
        logic [20:0] a;
        @(posedge clk);
        #1;
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(expect_vec(exp_state, op, z, mr, 1'b1));
        @(negedge clk);
        e = exp_q.pop_front();
        a = actual_vec();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s state=%0d got=%h want=%h", name, exp_state, a, e);
        end
        pc_cnt += int'(pcwrite);
        ir_cnt += int'(irwrite);
        rw_cnt += int'(regwrite);
        mw_cnt += int'(memwrite);
        il_cnt += int'(illegal);
    endtask

    task automatic check_count(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic [20:0] e;
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 7'b0110011;
        #3;
        exp_q.push_back(expect_vec(4'd0, op, 1'b0, 1'b0, 1'b0));
        e = exp_q.pop_front();
        total++;
        if (actual_vec() !== e) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", actual_vec(), e);
        end
        #9 rst_n = 1'b1;
        cyc("reset_release", 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_rtype();
        op = 7'b0110011; clear_counts();
        cyc("r_fetch",  1'b1, 1'b0, 4'd0);
        cyc("r_decode", 1'b1, 1'b0, 4'd1);
        cyc("r_exec",   1'b1, 1'b0, 4'd6);
        cyc("r_aluwb",  1'b1, 1'b0, 4'd8);
        cyc("r_next",   1'b0, 1'b0, 4'd0);
        check_count("r_pcwrite_cnt", pc_cnt, 1);
        check_count("r_regwrite_cnt", rw_cnt, 1);
    endtask

    task automatic test_itype();
        op = 7'b0010011;
        cyc("i_fetch",  1'b1, 1'b0, 4'd0);
        cyc("i_decode", 1'b1, 1'b0, 4'd1);
        cyc("i_exec",   1'b1, 1'b0, 4'd7);
        cyc("i_aluwb",  1'b1, 1'b0, 4'd8);
        cyc("i_next",   1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_lw_stall();
        op = 7'b0000011; clear_counts();
        cyc("lw_fetch_w0", 1'b0, 1'b0, 4'd0);
        cyc("lw_fetch_w1", 1'b0, 1'b0, 4'd0);
        cyc("lw_fetch_w2", 1'b0, 1'b0, 4'd0);
        cyc("lw_fetch",    1'b1, 1'b0, 4'd0);
        cyc("lw_decode",   1'b0, 1'b0, 4'd1);
        cyc("lw_memadr",   1'b0, 1'b0, 4'd2);
        cyc("lw_read_w0",  1'b0, 1'b0, 4'd3);
        cyc("lw_read_w1",  1'b0, 1'b0, 4'd3);
        cyc("lw_read",     1'b1, 1'b0, 4'd3);
        cyc("lw_memwb",    1'b1, 1'b0, 4'd4);
        cyc("lw_next",     1'b0, 1'b0, 4'd0);
        check_count("lw_irwrite_cnt", ir_cnt, 1);
    endtask

    task automatic test_sw();
        op = 7'b0100011; clear_counts();
        cyc("sw_fetch",   1'b1, 1'b0, 4'd0);
        cyc("sw_decode",  1'b1, 1'b0, 4'd1);
        cyc("sw_memadr",  1'b1, 1'b0, 4'd2);
        cyc("sw_write_w", 1'b0, 1'b0, 4'd5);
        cyc("sw_write",   1'b1, 1'b0, 4'd5);
        cyc("sw_next",    1'b0, 1'b0, 4'd0);
        check_count("sw_regwrite_cnt", rw_cnt, 0);
        check_count("sw_memwrite_cnt", mw_cnt, 2);
    endtask

    task automatic test_beq(input logic z);
        op = 7'b1100011; clear_counts();
        cyc("beq_fetch",  1'b1, z, 4'd0);
        cyc("beq_decode", 1'b1, z, 4'd1);
        cyc("beq_exec",   1'b1, z, 4'd9);
        cyc("beq_next",   1'b0, z, 4'd0);
        check_count("beq_pcwrite_cnt", pc_cnt, z ? 2 : 1);
    endtask

    task automatic test_jal();
        op = 7'b1101111; clear_counts();
        cyc("jal_fetch",  1'b1, 1'b0, 4'd0);
        cyc("jal_decode", 1'b1, 1'b0, 4'd1);
        cyc("jal_jal",    1'b1, 1'b0, 4'd10);
        cyc("jal_aluwb",  1'b1, 1'b0, 4'd8);
        cyc("jal_next",   1'b0, 1'b0, 4'd0);
        check_count("jal_pcwrite_cnt", pc_cnt, 2);
    endtask

    task automatic test_trap();
        op = 7'b0000000; clear_counts();
        cyc("trap_fetch",  1'b1, 1'b0, 4'd0);
        cyc("trap_decode", 1'b1, 1'b0, 4'd1);
        cyc("trap_trap",   1'b1, 1'b0, 4'd11);
        cyc("trap_next",   1'b0, 1'b0, 4'd0);
        check_count("trap_illegal_cnt", il_cnt, 1);
        check_count("trap_regwrite_cnt", rw_cnt, 0);
        check_count("trap_memwrite_cnt", mw_cnt, 0);
        check_count("trap_pcwrite_cnt", pc_cnt, 1);
    endtask

    task automatic test_reset_mid_write();
        op = 7'b0100011;
        cyc("rmw_fetch",  1'b1, 1'b0, 4'd0);
        cyc("rmw_decode", 1'b1, 1'b0, 4'd1);
        cyc("rmw_memadr", 1'b1, 1'b0, 4'd2);
        cyc("rmw_write",  1'b0, 1'b0, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({state, memwrite, mem_req} !== {4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rmw_async got=%h want=%h", {state, memwrite, mem_req}, 6'h00);
        end
        @(posedge clk);
        #1;
        total++;
        if ({state, pcwrite, irwrite, memwrite, mem_req, regwrite, illegal} !== 10'h000) begin
            bad++;
            $display("FAIL rmw_held got=%h want=%h",
                     {state, pcwrite, irwrite, memwrite, mem_req, regwrite, illegal}, 10'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rmw_fetch_after", 1'b1, 1'b0, 4'd0);
        cyc("rmw_decode_after", 1'b0, 1'b0, 4'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_counts();
        test_reset();
        test_rtype();
        test_itype();
        test_lw_stall();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal();
        test_trap();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
